// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter path: default width and
// direction encodings for the up/down control.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : gray_pkg

// File: rtl/gray_code_counter_if.sv
// Control and result bundle of the Gray-code counter. The master drives the
// count controls; the slave (the counter) returns the registered images.
interface gray_code_counter_if #(
  parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output en, up, load, load_bin,
    input  bin, gray, wrap
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, gray, wrap
  );

endinterface : gray_code_counter_if

// File: rtl/gray_code_counter_binary_to_gray.sv
// Combinational binary-to-Gray encoder; the inverse of the gray_to_binary
// decoder used at the receiving end of the Gray-code path.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule : binary_to_gray

// File: rtl/gray_code_counter.sv
// Up/down counter keeping a binary count and its Gray image in lock-step.
// Gray is encoded from the next binary value so both update on the same edge.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_code_counter_if.slave cnt_if
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next-state mux: load beats count enable, which beats hold.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (cnt_if.load) begin
      bin_d = cnt_if.load_bin;
    end else if (cnt_if.en) begin
      if (cnt_if.up == DIR_UP) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ALL1);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == ZERO);
      end
    end
  end

  binary_to_gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_if.bin  = bin_q;
  assign cnt_if.gray = gray_q;
  assign cnt_if.wrap = wrap_q;

endmodule : gray_code_counter

// File: tb/tb_gray_code_counter.sv
// Directed and random checks of gray_code_counter at WIDTH = 4.
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  gray_code_counter_if #(.WIDTH(W)) cnt_if ();

  gray_code_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_if (cnt_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic drive(input logic en, input logic up, input logic load, input logic [W-1:0] lb);
    cnt_if.en       = en;
    cnt_if.up       = up;
    cnt_if.load     = load;
    cnt_if.load_bin = lb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, DIR_UP, 1'b0, '0);
    rst_n = 1'b0;
    #3;
    check("reset_bin",  cnt_if.bin,  4'b0000);
    check("reset_gray", cnt_if.gray, 4'b0000);
    check("reset_wrap", W'(cnt_if.wrap), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  logic [W-1:0] lap_gray [16];
  logic [W-1:0] exp_bin;
  logic [W-1:0] prev_gray;
  logic         exp_wrap;
  logic         r_en, r_up;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    drive(1'b0, DIR_UP, 1'b0, '0);
    lap_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    #2;

    // Full up lap
    do_reset();
    drive(1'b1, DIR_UP, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("lap_gray[%0d]", i), cnt_if.gray, lap_gray[i]);
      check($sformatf("lap_dec[%0d]", i), gray2bin(cnt_if.gray), cnt_if.bin);
      check($sformatf("lap_wrap[%0d]", i), W'(cnt_if.wrap), (i == 15) ? 4'd1 : 4'd0);
    end

    // Count down from reset
    do_reset();
    drive(1'b1, DIR_DOWN, 1'b0, '0);
    step();
    check("down1_bin",  cnt_if.bin,  4'b1111);
    check("down1_gray", cnt_if.gray, 4'b1000);
    check("down1_wrap", W'(cnt_if.wrap), 4'd1);
    step();
    check("down2_bin",  cnt_if.bin,  4'b1110);
    check("down2_gray", cnt_if.gray, 4'b1001);
    check("down2_wrap", W'(cnt_if.wrap), 4'd0);

    // Back-to-back wraps alternating direction at the boundary
    drive(1'b1, DIR_UP, 1'b0, '0);
    step();
    step();
    check("b2b_up_bin",  cnt_if.bin, 4'b0000);
    check("b2b_up_wrap", W'(cnt_if.wrap), 4'd1);
    drive(1'b1, DIR_DOWN, 1'b0, '0);
    step();
    check("b2b_dn_bin",  cnt_if.bin, 4'b1111);
    check("b2b_dn_wrap", W'(cnt_if.wrap), 4'd1);

    // Load, hold, load priority
    drive(1'b0, DIR_UP, 1'b1, 4'b1010);
    step();
    check("load_bin",  cnt_if.bin,  4'b1010);
    check("load_gray", cnt_if.gray, 4'b1111);
    check("load_wrap", W'(cnt_if.wrap), 4'd0);
    drive(1'b0, DIR_DOWN, 1'b0, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_bin[%0d]", i),  cnt_if.bin,  4'b1010);
      check($sformatf("hold_gray[%0d]", i), cnt_if.gray, 4'b1111);
    end
    drive(1'b0, DIR_UP, 1'b1, 4'b1111);
    step();
    drive(1'b1, DIR_UP, 1'b1, 4'b0011);
    step();
    check("prio_bin",  cnt_if.bin,  4'b0011);
    check("prio_gray", cnt_if.gray, 4'b0010);
    check("prio_wrap", W'(cnt_if.wrap), 4'd0);

    // Asynchronous reset mid-count
    do_reset();
    drive(1'b1, DIR_UP, 1'b0, '0);
    for (int i = 0; i < 6; i++) step();
    check("pre_arst_bin", cnt_if.bin, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bin",  cnt_if.bin,  4'b0000);
    check("arst_gray", cnt_if.gray, 4'b0000);
    check("arst_wrap", W'(cnt_if.wrap), 4'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_arst_gray", cnt_if.gray, 4'b0001);
    check("post_arst_bin",  cnt_if.bin,  4'b0001);

    // Random en/up with a reference model
    do_reset();
    exp_bin = '0;
    for (int i = 0; i < 1000; i++) begin
      r_en = 1'($urandom_range(0, 3) != 0);
      r_up = 1'($urandom_range(0, 1));
      drive(r_en, r_up, 1'b0, W'($urandom));
      prev_gray = cnt_if.gray;
      exp_wrap  = 1'b0;
      if (r_en) begin
        if (r_up) begin
          exp_wrap = (exp_bin == 4'b1111);
          exp_bin  = exp_bin + 4'd1;
        end else begin
          exp_wrap = (exp_bin == 4'b0000);
          exp_bin  = exp_bin - 4'd1;
        end
      end
      step();
      check("rnd_bin",  cnt_if.bin, exp_bin);
      check("rnd_gray", cnt_if.gray, exp_bin ^ (exp_bin >> 1));
      check("rnd_wrap", W'(cnt_if.wrap), W'(exp_wrap));
      check("rnd_dist", W'($countones(prev_gray ^ cnt_if.gray)), r_en ? 4'd1 : 4'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_gray_code_counter
